// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer: launch FSM encoding,
// link clock/baud constants and default buffer sizing.
package uart_pkg;

   localparam int CLK_FREQ            = 50000000;
   localparam int UART_BPS            = 115200;
   localparam int DEFAULT_DEPTH       = 16;
   localparam int DEFAULT_ADDR_W      = 4;
   localparam int DEFAULT_ACK_TIMEOUT = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_GAP       = 3'd3,
      ST_ERROR     = 3'd4
   } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered count/empty/full; read data is the
// current head entry (no write-to-read bypass).
module sync_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              rd_en,
   output logic [7:0]        rd_data,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full
);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              do_wr_s, do_rd_s;

   // Qualify requests against the current flags so the pointers never overrun.
   always_comb begin
      do_wr_s  = wr_en && !full_q;
      do_rd_s  = rd_en && !empty_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr_s) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_rd_s) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_wr_s, do_rd_s})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase
      empty_d = (count_d == (ADDR_W+1)'(0));
      full_d  = (count_d == (ADDR_W+1)'(DEPTH));
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   // Storage array; contents are don't-care while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_wr_s) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign empty   = empty_q;
   assign full    = full_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte buffer and launch controller feeding an 8N1 UART transmitter.
// Optional UART_TX_BUF_STATS_EN adds sent_count / drop_count statistics ports.
module uart_tx_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter int ADDR_W      = DEFAULT_ADDR_W,
   parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
   input  logic              hs_clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              uart_tx_en,
   output logic [7:0]        uart_tx_data,
   input  logic              uart_tx_busy,
   input  logic              tx_done,
   input  logic              tx_error,
   output logic [ADDR_W:0]   fifo_count,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              link_error
`ifdef UART_TX_BUF_STATS_EN
   ,
   output logic [15:0]       sent_count,
   output logic [15:0]       drop_count
`endif
);

   localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;

   tx_state_e         state_q, state_d;
   logic              en_q, en_d;
   logic [7:0]        data_q, data_d;
   logic              err_q, err_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              pop_s;
   logic              push_s;
   logic [7:0]        head_s;

   assign in_ready = !fifo_full;
   assign push_s   = in_valid && in_ready;

   sync_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (hs_clk),
      .rst_n   (rst_n),
      .wr_en   (push_s),
      .wr_data (in_data),
      .rd_en   (pop_s),
      .rd_data (head_s),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // Launch FSM: transmitter error overrides every state and parks in ERROR.
   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      data_d  = data_q;
      err_d   = err_q;
      timer_d = timer_q;
      pop_s   = 1'b0;
      if (tx_error) begin
         err_d   = 1'b1;
         en_d    = 1'b0;
         state_d = ST_ERROR;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty && !uart_tx_busy) begin
                  pop_s   = 1'b1;
                  data_d  = head_s;
                  en_d    = 1'b1;
                  timer_d = '0;
                  state_d = ST_LAUNCH;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LAUNCH: begin
               if (uart_tx_busy) begin
                  en_d    = 1'b0;
                  state_d = ST_WAIT_DONE;
               end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  en_d    = 1'b0;
                  state_d = ST_ERROR;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (tx_done) begin
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_WAIT_DONE;
               end
            end
            // Holding here until busy drops keeps the enable low long enough
            // for the transmitter's edge detector to re-arm.
            ST_GAP: begin
               if (!uart_tx_busy) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_GAP;
               end
            end
            ST_ERROR: begin
               en_d    = 1'b0;
               state_d = ST_ERROR;
            end
            default: begin
               err_d   = 1'b1;
               en_d    = 1'b0;
               state_d = ST_ERROR;
            end
         endcase
      end
   end

   // FSM and transmitter-facing output registers.
   always_ff @(posedge hs_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         en_q    <= 1'b0;
         data_q  <= 8'h00;
         err_q   <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         data_q  <= data_d;
         err_q   <= err_d;
         timer_q <= timer_d;
      end
   end

   assign uart_tx_en   = en_q;
   assign uart_tx_data = data_q;
   assign link_error   = err_q;

`ifdef UART_TX_BUF_STATS_EN
   logic [15:0] sent_q, sent_d;
   logic [15:0] drop_q, drop_d;

   // Completed-frame count wraps; rejected-write count saturates.
   always_comb begin
      sent_d = sent_q;
      drop_d = drop_q;
      if (state_q == ST_WAIT_DONE && tx_done) begin
         sent_d = sent_q + 16'd1;
      end else begin
         sent_d = sent_q;
      end
      if (in_valid && !in_ready && drop_q != 16'hFFFF) begin
         drop_d = drop_q + 16'd1;
      end else begin
         drop_d = drop_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge hs_clk or negedge rst_n) begin
      if (!rst_n) begin
         sent_q <= 16'd0;
         drop_q <= 16'd0;
      end else begin
         sent_q <= sent_d;
         drop_q <= drop_d;
      end
   end

   assign sent_count = sent_q;
   assign drop_count = drop_q;
`endif

endmodule
